// File: rtl/grid_arbiter_if.sv
// Bundle of sync, renderer, game-engine and RAM-port signals around the tile-grid arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface grid_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2
);
  logic              vsync;
  logic              video_on;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic [DATA_W-1:0] game_wdata;
  logic              game_gnt;
  logic              game_rvalid;
  logic [DATA_W-1:0] game_rdata;
  logic              game_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              step_tick;
  logic              step_active;
  logic              overrun;

  modport slave (
    input  vsync, video_on, rd_req, rd_addr, game_req, game_we, game_addr,
           game_wdata, game_done, ram_rdata,
    output rd_data, rd_valid, game_gnt, game_rvalid, game_rdata,
           ram_addr, ram_we, ram_wdata, step_tick, step_active, overrun
  );

  modport master (
    output vsync, video_on, rd_req, rd_addr, game_req, game_we, game_addr,
           game_wdata, game_done, ram_rdata,
    input  rd_data, rd_valid, game_gnt, game_rvalid, game_rdata,
           ram_addr, ram_we, ram_wdata, step_tick, step_active, overrun
  );
endinterface

// File: rtl/grid_arbiter.sv
// Shares one single-port tile RAM between the VGA renderer and the game engine,
// and paces game steps from vsync (one step every TICK_FRAMES frames).
module grid_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 2,
  parameter int TICK_FRAMES = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  grid_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STEP  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [7:0] LAST_FRAME = 8'(TICK_FRAMES - 1);

  logic       vsync_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       step_tick_q, step_tick_d;
  logic [1:0] state_q, state_d;
  logic       overrun_q, overrun_d;
  logic       rd_valid_q;
  logic       game_rvalid_q, game_rvalid_d;

  logic frame_evt;
  logic renderer_own;
  logic game_own;
  logic game_gnt;

  assign frame_evt = vsync_q & ~bus.vsync;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_tick_d = 1'b0;
    if (frame_evt) begin
      if (frame_cnt_q == LAST_FRAME) begin
        frame_cnt_d = 8'd0;
        step_tick_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // game_done takes precedence over the video_on driven STEP/STALL swaps
  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (step_tick_q) state_d = S_STEP;
      end
      S_STEP: begin
        if (step_tick_q) overrun_d = 1'b1;
        if (bus.game_done)     state_d = S_IDLE;
        else if (bus.video_on) state_d = S_STALL;
      end
      S_STALL: begin
        if (step_tick_q) overrun_d = 1'b1;
        if (bus.game_done)      state_d = S_IDLE;
        else if (!bus.video_on) state_d = S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign renderer_own = bus.video_on | bus.rd_req;
  assign game_own     = (state_q == S_STEP) & ~renderer_own;
  assign game_gnt     = game_own & bus.game_req;

  assign game_rvalid_d = game_gnt & ~bus.game_we;

  assign bus.ram_addr  = renderer_own ? bus.rd_addr :
                         game_gnt     ? bus.game_addr : '0;
  assign bus.ram_we    = game_gnt & bus.game_we;
  assign bus.ram_wdata = game_gnt ? bus.game_wdata : '0;

  assign bus.game_gnt    = game_gnt;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = bus.ram_rdata;
  assign bus.game_rvalid = game_rvalid_q;
  assign bus.game_rdata  = bus.ram_rdata;
  assign bus.step_tick   = step_tick_q;
  assign bus.step_active = (state_q != S_IDLE);
  assign bus.overrun     = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b1;
      frame_cnt_q   <= 8'd0;
      step_tick_q   <= 1'b0;
      state_q       <= S_IDLE;
      overrun_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      game_rvalid_q <= 1'b0;
    end else begin
      vsync_q       <= bus.vsync;
      frame_cnt_q   <= frame_cnt_d;
      step_tick_q   <= step_tick_d;
      state_q       <= state_d;
      overrun_q     <= overrun_d;
      rd_valid_q    <= bus.rd_req;
      game_rvalid_q <= game_rvalid_d;
    end
  end

endmodule

// File: tb/tb_grid_arbiter.sv
// Randomized bench for grid_arbiter: a rule-level model of step pacing, ownership and a
// shadow tile map is compared against the DUT every negedge, plus directed literal checks.
module tb_grid_arbiter;
  localparam int AW = 11;
  localparam int DW = 2;
  localparam int TF = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  grid_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  grid_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  grid_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TICK_FRAMES(TF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  grid_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TICK_FRAMES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  assign bus1.vsync = bus.vsync;

  // Tile RAM with one-cycle registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: phase 0=idle, 1=stepping, 2=stalled
  int            m_phase;
  int            m_frames;
  bit            m_pv, m_tick, m_tick1, m_ov, m_rdv, m_grv;
  logic [DW-1:0] m_rdd, m_grd;
  logic [DW-1:0] gold [0:(1<<AW)-1];

  int tick_seen = 0;
  int tick_at [2];
  int edge_idx  = 0;
  bit g_last    = 1'b0;

  always @(negedge clk) begin : model_blk
    bit            mgnt, fell;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    if (!rst_n) begin
      chk("rst_step_tick",   32'(bus.step_tick),   32'd0);
      chk("rst_step_active", 32'(bus.step_active), 32'd0);
      chk("rst_overrun",     32'(bus.overrun),     32'd0);
      chk("rst_rd_valid",    32'(bus.rd_valid),    32'd0);
      chk("rst_game_rvalid", 32'(bus.game_rvalid), 32'd0);
      chk("rst_game_gnt",    32'(bus.game_gnt),    32'd0);
      chk("rst_ram_we",      32'(bus.ram_we),      32'd0);
      chk("rst_tick1",       32'(bus1.step_tick),  32'd0);
      m_phase = 0; m_frames = 0; m_pv = 1'b1; m_tick = 1'b0; m_tick1 = 1'b0;
      m_ov = 1'b0; m_rdv = 1'b0; m_grv = 1'b0;
    end else begin
      mgnt = (m_phase == 1) && !bus.video_on && !bus.rd_req && bus.game_req;
      if (bus.video_on || bus.rd_req) ea = bus.rd_addr;
      else if (mgnt)                  ea = bus.game_addr;
      else                            ea = '0;
      ew = mgnt ? bus.game_wdata : '0;
      chk("step_tick",   32'(bus.step_tick),   32'(m_tick));
      chk("step_active", 32'(bus.step_active), 32'(m_phase != 0));
      chk("overrun",     32'(bus.overrun),     32'(m_ov));
      chk("rd_valid",    32'(bus.rd_valid),    32'(m_rdv));
      if (m_rdv) chk("rd_data", 32'(bus.rd_data), 32'(m_rdd));
      chk("game_gnt",    32'(bus.game_gnt),    32'(mgnt));
      chk("game_rvalid", 32'(bus.game_rvalid), 32'(m_grv));
      if (m_grv) chk("game_rdata", 32'(bus.game_rdata), 32'(m_grd));
      chk("ram_we",      32'(bus.ram_we),      32'(mgnt && bus.game_we));
      chk("ram_addr",    32'(bus.ram_addr),    32'(ea));
      chk("ram_wdata",   32'(bus.ram_wdata),   32'(ew));
      chk("tick1",       32'(bus1.step_tick),  32'(m_tick1));

      fell    = m_pv && !bus.vsync;
      m_pv    = bus.vsync;
      m_tick1 = fell;
      case (m_phase)
        0: if (m_tick) m_phase = 1;
        1: begin
          if (m_tick) m_ov = 1'b1;
          if (bus.game_done)     m_phase = 0;
          else if (bus.video_on) m_phase = 2;
        end
        default: begin
          if (m_tick) m_ov = 1'b1;
          if (bus.game_done)      m_phase = 0;
          else if (!bus.video_on) m_phase = 1;
        end
      endcase
      m_rdv = bus.rd_req;
      m_rdd = gold[bus.rd_addr];
      m_grv = mgnt && !bus.game_we;
      m_grd = gold[bus.game_addr];
      if (mgnt && bus.game_we) gold[bus.game_addr] = bus.game_wdata;
      m_tick = 1'b0;
      if (fell) begin
        if (m_frames == TF - 1) begin
          m_frames = 0;
          m_tick   = 1'b1;
        end else begin
          m_frames++;
        end
      end
    end
    if (bus.step_tick) begin
      if (tick_seen < 2) tick_at[tick_seen] = edge_idx;
      tick_seen++;
    end
    g_last = bus.game_gnt;
  end

  task automatic nxt(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_edge();
    bus.vsync = 1'b0;
    nxt(2);
    bus.vsync = 1'b1;
    nxt(2);
  endtask

  initial begin
    bit pend;
    int p;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    rst_n = 1'b0;
    bus.vsync = 1'b1; bus.video_on = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    bus.game_done = 1'b0;
    bus1.video_on = 1'b0; bus1.rd_req = 1'b0; bus1.rd_addr = '0; bus1.game_req = 1'b0;
    bus1.game_we = 1'b0; bus1.game_addr = '0; bus1.game_wdata = '0; bus1.game_done = 1'b0;
    bus1.ram_rdata = '0;
    nxt(3);
    rst_n = 1'b1;
    nxt(2);

    // Cadence: 16 edges -> ticks on edges 8 and 16; the second lands mid-step
    for (int e = 1; e <= 16; e++) begin
      edge_idx = e;
      frame_edge();
    end
    edge_idx = 0;
    chk("tick_count",  32'(tick_seen),  32'd2);
    chk("tick_edge_a", 32'(tick_at[0]), 32'd8);
    chk("tick_edge_b", 32'(tick_at[1]), 32'd16);
    chk("ovr_set",     32'(bus.overrun),     32'd1);
    chk("ovr_active",  32'(bus.step_active), 32'd1);

    bus.game_done = 1'b1;
    nxt(1);
    bus.game_done = 1'b0;
    #1;
    chk("done_idle",   32'(bus.step_active), 32'd0);
    chk("ovr_sticky",  32'(bus.overrun),     32'd1);

    for (int e = 0; e < 8; e++) frame_edge();
    #1;
    chk("restep", 32'(bus.step_active), 32'd1);

    // Blanking write of 2 to tile 37, then renderer read-back
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 11'd37; bus.game_wdata = 2'd2;
    #1;
    chk("wr_gnt", 32'(bus.game_gnt), 32'd1);
    nxt(1);
    bus.game_req = 1'b0; bus.game_we = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 11'd37;
    nxt(1);
    bus.rd_req = 1'b0;
    #1;
    chk("rb_valid", 32'(bus.rd_valid), 32'd1);
    chk("rb_data",  32'(bus.rd_data),  32'd2);

    // Stall: request held across the active region
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 11'd37;
    bus.video_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gnt", 32'(bus.game_gnt), 32'd0);
      chk("stall_we",  32'(bus.ram_we),   32'd0);
      nxt(1);
    end
    bus.video_on = 1'b0;
    nxt(1);
    #1;
    chk("unstall_gnt", 32'(bus.game_gnt), 32'd1);
    nxt(1);
    bus.game_req = 1'b0;
    #1;
    chk("unstall_rv", 32'(bus.game_rvalid), 32'd1);
    chk("unstall_rd", 32'(bus.game_rdata),  32'd2);

    // Collision: renderer wins, game granted once rd_req drops
    bus.rd_req = 1'b1; bus.rd_addr = 11'd5; bus.game_req = 1'b1;
    #1;
    chk("col_addr", 32'(bus.ram_addr), 32'd5);
    chk("col_gnt",  32'(bus.game_gnt), 32'd0);
    nxt(1);
    bus.rd_req = 1'b0;
    #1;
    chk("col_gnt2", 32'(bus.game_gnt), 32'd1);
    nxt(1);
    bus.game_req = 1'b0;

    // Reset just after a granted read
    bus.game_req = 1'b1; bus.game_addr = 11'd37;
    #1;
    chk("rr_gnt", 32'(bus.game_gnt), 32'd1);
    nxt(1);
    bus.game_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_rvalid", 32'(bus.game_rvalid), 32'd0);
    chk("rr_active", 32'(bus.step_active), 32'd0);
    chk("rr_ovr",    32'(bus.overrun),     32'd0);
    nxt(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr_after", 32'(bus.game_rvalid), 32'd0);
      nxt(1);
    end

    // Randomized traffic: 50-cycle frames, random renderer reads, a holding game agent
    pend = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      p = c % 50;
      bus.vsync    = (p < 3) ? 1'b0 : 1'b1;
      bus.video_on = (p >= 10 && p < 40);
      bus.rd_req   = ($urandom_range(0, 9) < 3);
      bus.rd_addr  = 11'($urandom_range(0, 63));
      if (pend && g_last) pend = 1'b0;
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend           = 1'b1;
        bus.game_we    = 1'($urandom_range(0, 1));
        bus.game_addr  = 11'($urandom_range(0, 63));
        bus.game_wdata = 2'($urandom_range(0, 3));
      end
      bus.game_req  = pend;
      bus.game_done = ($urandom_range(0, 99) == 0);
      nxt(1);
    end
    bus.game_req = 1'b0; bus.rd_req = 1'b0; bus.game_done = 1'b0;
    nxt(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
